// File: rtl/piece_queue.sv
// Purpose : preview buffer between the piece generator and the game controller.
// Latency : a piece accepted at a clock edge is visible on head/preview/count after that edge.
// Backpr. : genenable drops while the queue is full; when full, a push is still taken alongside a pop.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   genready/genpiece - generator candidate (code 7 is invalid and discarded)
//   genenable         - generator enable, high while the queue can accept (combinational)
//   pop               - controller consumes the head piece (honoured only while valid)
//   valid             - head/preview meaningful (registered state only)
//   head              - oldest piece (entry 0)
//   preview           - all entries, entry i at [3i+2:3i], unused entries read 0
//   count             - number of stored pieces
//
// Optional feature macro: PIECEQUEUE_NOREPEAT_EN drops the first immediate repeat of
// the last pushed piece (at most one consecutive drop).
module piece_queue #(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               genready,
  input  logic [2:0]         genpiece,
  output logic               genenable,
  input  logic               pop,
  output logic               valid,
  output logic [2:0]         head,
  output logic [3*DEPTH-1:0] preview,
  output logic [CW-1:0]      count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t                state, state_nxt;
  logic [DEPTH-1:0][2:0] q, q_nxt;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         widx;
  logic                  cand, room, fits, popacc, pushacc;

  assign cand    = genready && (genpiece != 3'd7);
  assign room    = (count < FULL);
  assign popacc  = pop && valid;
  // A pop frees a slot in the same cycle, so a full queue can still take a push.
  assign fits    = cand && (room || popacc);

`ifdef PIECEQUEUE_NOREPEAT_EN
  logic [2:0] lastpiece;
  logic       rerolled;
  logic       repdrop;

  // Only a candidate that would otherwise be stored counts as a dropped repeat.
  assign repdrop = fits && !rerolled && (genpiece == lastpiece);
  assign pushacc = fits && !repdrop;

  always_ff @(posedge clk) begin
    if (reset) begin
      lastpiece <= 3'd7;
      rerolled  <= 1'b0;
    end else if (pushacc) begin
      lastpiece <= genpiece;
      rerolled  <= 1'b0;
    end else if (repdrop) begin
      rerolled  <= 1'b1;
    end
  end
`else
  assign pushacc = fits;
`endif

  assign genenable = room && !reset;
  assign head      = q[0];
  assign preview   = q;

  // Write slot: the tail, which moves down by one when a pop shifts the queue.
  assign widx = popacc ? (count - CW'(1)) : count;

  always_comb begin
    q_nxt = popacc ? (q >> 3) : q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pushacc && (CW'(i) == widx)) begin
        q_nxt[i] = genpiece;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({pushacc, popacc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // FSM next state and output decode.
  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    case (state)
      FILL: begin
        valid = 1'b0;
        if (count_nxt == FULL) state_nxt = RUN;
      end
      RUN: begin
        valid = (count != '0);
        if (count_nxt == '0) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Purpose : self-checking bench for piece_queue (DEPTH=3) using a table of directed vectors.
// Latency : each vector is driven, one clock edge passes, then outputs are sampled 1 time unit later.
// Backpr. : genenable is checked against the inputs still held after the edge.
module tb_piece_queue;

  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               genready;
  logic [2:0]         genpiece;
  logic               genenable;
  logic               pop;
  logic               valid;
  logic [2:0]         head;
  logic [3*DEPTH-1:0] preview;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .genready  (genready),
    .genpiece  (genpiece),
    .genenable (genenable),
    .pop       (pop),
    .valid     (valid),
    .head      (head),
    .preview   (preview),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       gr;
    logic [2:0] gp;
    logic       pp;
    int         ecount;
    logic       evalid;
    logic [2:0] ehead;
    logic [8:0] eprev;
    logic       egen;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic rst, input logic gr, input logic [2:0] gp,
                               input logic pp, input int ec, input logic ev,
                               input logic [2:0] eh, input logic [8:0] ep, input logic eg);
    vec_t v;
    v.rst = rst; v.gr = gr; v.gp = gp; v.pp = pp;
    v.ecount = ec; v.evalid = ev; v.ehead = eh; v.eprev = ep; v.egen = eg;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic gr, input logic [2:0] gp, input logic pp);
    reset    = rst;
    genready = gr;
    genpiece = gp;
    pop      = pp;
  endtask

  int   model[$];
  int   waited;
  logic [2:0] np;

  initial begin
    drive(1'b1, 1'b0, 3'd0, 1'b0);

    // Reset, including a push and pop attempt during reset.
    addv(1, 0, 0, 0, 0, 0, 0, 9'o000, 0);
    addv(1, 1, 3, 1, 0, 0, 0, 9'o000, 0);
    // Invalid code 7 is filtered.
    for (int i = 0; i < 4; i++) addv(0, 1, 7, 0, 0, 0, 0, 9'o000, 1);
    // Fill with 2,5,1.
    addv(0, 1, 2, 0, 1, 0, 2, 9'o002, 1);
    addv(0, 1, 5, 0, 2, 0, 2, 9'o052, 1);
    addv(0, 1, 1, 0, 3, 1, 2, 9'o152, 0);
    // Full, no pop: push rejected.
    addv(0, 1, 6, 0, 3, 1, 2, 9'o152, 0);
    // Pop with push while full.
    addv(0, 1, 4, 1, 3, 1, 5, 9'o415, 0);
    // Pop with invalid candidate, then plain pops down to empty.
    addv(0, 1, 7, 1, 2, 1, 1, 9'o041, 1);
    addv(0, 0, 0, 1, 1, 1, 4, 9'o004, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 9'o000, 1);
    // Pop while empty ignored.
    addv(0, 0, 0, 1, 0, 0, 0, 9'o000, 1);
    // Pop ignored in FILL, push still taken.
    addv(0, 1, 3, 1, 1, 0, 3, 9'o003, 1);
    addv(0, 1, 6, 0, 2, 0, 3, 9'o063, 1);
    addv(0, 0, 0, 1, 2, 0, 3, 9'o063, 1);
    addv(0, 1, 0, 0, 3, 1, 3, 9'o063, 0);
    // Drain {3,6,0} back to FILL; the 4th pop is ignored.
    addv(0, 0, 0, 1, 2, 1, 6, 9'o006, 1);
    addv(0, 0, 0, 1, 1, 1, 0, 9'o000, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 9'o000, 1);
    addv(0, 0, 0, 1, 0, 0, 0, 9'o000, 1);
    // Reset mid-run with a pop and a candidate in the reset cycle.
    addv(0, 1, 1, 0, 1, 0, 1, 9'o001, 1);
    addv(0, 1, 2, 0, 2, 0, 1, 9'o021, 1);
    addv(0, 1, 3, 0, 3, 1, 1, 9'o321, 0);
    addv(1, 1, 4, 1, 0, 0, 0, 9'o000, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 9'o000, 1);
`ifdef PIECEQUEUE_NOREPEAT_EN
    // Second consecutive 4 dropped, third accepted.
    addv(0, 1, 4, 0, 1, 0, 4, 9'o004, 1);
    addv(0, 1, 4, 0, 1, 0, 4, 9'o004, 1);
    addv(0, 1, 4, 0, 2, 0, 4, 9'o044, 1);
`else
    // Repeats are accepted.
    addv(0, 1, 4, 0, 1, 0, 4, 9'o004, 1);
    addv(0, 1, 4, 0, 2, 0, 4, 9'o044, 1);
    addv(0, 1, 4, 0, 3, 1, 4, 9'o444, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].gr, vecs[i].gp, vecs[i].pp);
      @(posedge clk);
      #1;
      chk("count",     i, int'(count),     vecs[i].ecount);
      chk("valid",     i, int'(valid),     int'(vecs[i].evalid));
      chk("head",      i, int'(head),      int'(vecs[i].ehead));
      chk("preview",   i, int'(preview),   int'(vecs[i].eprev));
      chk("genenable", i, int'(genenable), int'(vecs[i].egen));
    end

    // Sustained pop+push every cycle against a small queue model.
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    model.delete();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b1, 3'(k), 1'b0);
      model.push_back(k);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    waited = 0;
    while (!valid && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("valid_timeout", 100, int'(valid), 1);
    for (int k = 0; k < 8; k++) begin
      np = 3'((k + 3) % 7);
      drive(1'b0, 1'b1, np, 1'b1);
      void'(model.pop_front());
      model.push_back(int'(np));
      @(posedge clk);
      #1;
      chk("stream_head",  200 + k, int'(head),  model[0]);
      chk("stream_count", 200 + k, int'(count), DEPTH);
      chk("stream_valid", 200 + k, int'(valid), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
